// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared definitions for the data-memory arbiter.
//   - DM_DEPTH / DM_WORDS_DEFAULT : data-memory depth in words (kept equal)
//   - BE_FULL                     : byte-enable pattern of a full-word store
//   - state_e                     : arbiter FSM encodings
package dm_arbiter_pkg;

  localparam int DM_DEPTH         = 3072;
  localparam int DM_WORDS_DEFAULT = DM_DEPTH;

  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

endpackage

// File: rtl/dm_be_merge.sv
// dm_be_merge: combinational byte-lane merge for read-modify-write stores.
// Ports:
//   old_i    : word currently held in DM
//   new_i    : lane-aligned store data
//   be_i     : byte enables, bit i selects new_i for bits [8i+7:8i]
//   merged_o : merged word
module dm_be_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_o[8*gi +: 8] = be_i[gi] ? new_i[8*gi +: 8] : old_i[8*gi +: 8];
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter/sequencer sharing the word-wide data memory
// between the pipeline MEM stage (m0) and an auxiliary master (m1).
// Loads return registered data one cycle after grant; partial stores become
// a two-cycle read-modify-write because DM only accepts full-word writes.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   mN_req/we/be/addr/wdata (N=0,1)  : requester side inputs
//   mN_gnt, mN_rvalid, mN_rdata      : grant (combinational) and load response
//   dm_addr, dm_wdata, dm_we         : DM drive
//   dm_rdata                         : DM combinational read data
// Optional feature: define DM_ARBITER_PERF_EN to add perf_grants0,
// perf_grants1 and perf_stalls counters.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
`ifdef DM_ARBITER_PERF_EN
  output logic [31:0] perf_grants0,
  output logic [31:0] perf_grants1,
  output logic [31:0] perf_stalls,
`endif
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;          // 0: m0 wins a tie, 1: m1 wins a tie
  logic [31:0] rmw_addr_q, rmw_data_q;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        grant0, grant1, granted;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr, sel_wdata, word_addr, merged;
  logic        in_range, do_write, start_rmw;

  // Grants are purely combinational; none while in reset or RMW_WR.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && state_q == ST_IDLE) begin
      if (m0_req && (!m1_req || !rr_q)) grant0 = 1'b1;
      else if (m1_req)                  grant1 = 1'b1;
    end
  end

  assign granted   = grant0 | grant1;
  assign sel_we    = grant1 ? m1_we    : m0_we;
  assign sel_be    = grant1 ? m1_be    : m0_be;
  assign sel_addr  = grant1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant1 ? m1_wdata : m0_wdata;
  assign word_addr = {sel_addr[31:2], 2'b00};
  assign in_range  = sel_addr < DM_BYTES;

  // Out-of-range and be=0 stores are accepted but touch nothing.
  assign do_write  = granted && sel_we && in_range && (sel_be == BE_FULL);
  assign start_rmw = granted && sel_we && in_range &&
                     (sel_be != 4'h0) && (sel_be != BE_FULL);

  dm_be_merge u_merge (
    .old_i    (dm_rdata),
    .new_i    (sel_wdata),
    .be_i     (sel_be),
    .merged_o (merged)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_we    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (granted) begin
            dm_addr = word_addr;
            rr_d    = grant0;   // point at the requester that just lost
            if (do_write) begin
              dm_we    = 1'b1;
              dm_wdata = sel_wdata;
            end
            if (start_rmw) state_d = ST_RMW_WR;
          end
        end
        ST_RMW_WR: begin
          dm_we    = 1'b1;
          dm_addr  = rmw_addr_q;
          dm_wdata = rmw_data_q;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      rmw_addr_q <= 32'h0;
      rmw_data_q <= 32'h0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      rvalid0_q <= grant0 && !m0_we;
      rvalid1_q <= grant1 && !m1_we;
      if (grant0 && !m0_we) rdata0_q <= in_range ? dm_rdata : 32'h0;
      if (grant1 && !m1_we) rdata1_q <= in_range ? dm_rdata : 32'h0;
      if (start_rmw) begin
        rmw_addr_q <= word_addr;
        rmw_data_q <= merged;
      end
    end
  end

  assign m0_gnt    = grant0;
  assign m1_gnt    = grant1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

`ifdef DM_ARBITER_PERF_EN
  logic [31:0] grants0_q, grants1_q, stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q <= 32'h0;
      grants1_q <= 32'h0;
      stalls_q  <= 32'h0;
    end else begin
      if (grant0) grants0_q <= grants0_q + 32'd1;
      if (grant1) grants1_q <= grants1_q + 32'd1;
      if ((m0_req && !grant0) || (m1_req && !grant1)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_grants0 = grants0_q;
  assign perf_grants1 = grants1_q;
  assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a simple
// behavioural data memory attached to the DM ports.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_we;

  int compared   = 0;
  int mismatched = 0;
  int we_count   = 0;
  int we_in_reset = 0;
  int we_snap;

  logic [31:0] mem [0:3071];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  // Out-of-range reads return all-ones so a zeroed load result is meaningful.
  assign dm_rdata = (dm_addr < 32'd12288) ? mem[dm_addr[13:2]] : 32'hFFFF_FFFF;

  always @(posedge clk) begin
    if (dm_we) begin
      we_count++;
      if (reset) we_in_reset++;
      if (dm_addr < 32'd12288) mem[dm_addr[13:2]] <= dm_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 0; m1_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
    mem[4] = 32'hCAFE_BABE;
    mem[5] = 32'hA5A5_0001;
    mem[6] = 32'h5A5A_0002;
    mem[8] = 32'h1122_3344;
    mem[9] = 32'h5566_7788;
    idle_inputs();

    // Reset: a pending request must not be granted and all outputs idle.
    reset = 1;
    m0_req = 1; m0_addr = 32'h10;
    tick(); tick();
    check("rst_gnt0", {31'h0, m0_gnt}, 32'h0);
    check("rst_gnt1", {31'h0, m1_gnt}, 32'h0);
    check("rst_rvalid0", {31'h0, m0_rvalid}, 32'h0);
    check("rst_rdata0", m0_rdata, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_wdata", dm_wdata, 32'h0);
    idle_inputs();
    reset = 0;
    tick();

    // Both load right after reset: m0 first, then strict alternation.
    m0_req = 1; m0_addr = 32'h14;
    m1_req = 1; m1_addr = 32'h18;
    #1;
    check("rr_c0_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("rr_c0_gnt1", {31'h0, m1_gnt}, 32'h0);
    check("rr_c0_dm_addr", dm_addr, 32'h14);
    tick();
    check("rr_c1_gnt1", {31'h0, m1_gnt}, 32'h1);
    check("rr_c1_gnt0", {31'h0, m0_gnt}, 32'h0);
    check("rr_c1_rvalid0", {31'h0, m0_rvalid}, 32'h1);
    check("rr_c1_rdata0", m0_rdata, 32'hA5A5_0001);
    tick();
    check("rr_c2_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("rr_c2_rvalid1", {31'h0, m1_rvalid}, 32'h1);
    check("rr_c2_rdata1", m1_rdata, 32'h5A5A_0002);
    tick();
    check("rr_c3_gnt1", {31'h0, m1_gnt}, 32'h1);
    tick();
    idle_inputs();
    #1;
    check("rr_idle_gnt0", {31'h0, m0_gnt}, 32'h0);
    tick();

    // m0 load 0x10: grant now, data one cycle later, single pulse.
    m0_req = 1; m0_addr = 32'h10;
    #1;
    check("ld_gnt0", {31'h0, m0_gnt}, 32'h1);
    tick();
    idle_inputs();
    #1;
    check("ld_rvalid0", {31'h0, m0_rvalid}, 32'h1);
    check("ld_rdata0", m0_rdata, 32'hCAFE_BABE);
    tick();
    check("ld_rvalid0_pulse", {31'h0, m0_rvalid}, 32'h0);

    // m1 sb into 0x20: read cycle, then RMW_WR; m0 waits one cycle.
    m1_req = 1; m1_we = 1; m1_be = 4'b0010; m1_addr = 32'h20; m1_wdata = 32'h0000_AB00;
    #1;
    check("rmw_gnt1", {31'h0, m1_gnt}, 32'h1);
    check("rmw_rd_dm_we", {31'h0, dm_we}, 32'h0);
    tick();
    idle_inputs();
    m0_req = 1; m0_addr = 32'h20;
    #1;
    check("rmw_wr_gnt0", {31'h0, m0_gnt}, 32'h0);
    check("rmw_wr_dm_we", {31'h0, dm_we}, 32'h1);
    check("rmw_wr_dm_addr", dm_addr, 32'h20);
    check("rmw_wr_dm_wdata", dm_wdata, 32'h1122_AB44);
    tick();
    check("rmw_mem8", mem[8], 32'h1122_AB44);
    check("rmw_late_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("rmw_no_rvalid1", {31'h0, m1_rvalid}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("rmw_ld_rdata0", m0_rdata, 32'h1122_AB44);
    tick();

    // m0 full store to 0x30, m1 reads it back next cycle.
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h30; m0_wdata = 32'h1234_5678;
    #1;
    check("fst_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("fst_dm_we", {31'h0, dm_we}, 32'h1);
    check("fst_dm_wdata", dm_wdata, 32'h1234_5678);
    tick();
    idle_inputs();
    m1_req = 1; m1_addr = 32'h30;
    #1;
    check("fst_ld_gnt1", {31'h0, m1_gnt}, 32'h1);
    check("fst_no_rvalid0", {31'h0, m0_rvalid}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("fst_ld_rdata1", m1_rdata, 32'h1234_5678);
    tick();

    // Out-of-range full and partial stores, then an out-of-range load.
    we_snap = we_count;
    m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h3000; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("oor_st_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("oor_st_dm_we", {31'h0, dm_we}, 32'h0);
    tick();
    idle_inputs();
    m1_req = 1; m1_we = 1; m1_be = 4'b0001; m1_addr = 32'h3000; m1_wdata = 32'h0000_00EE;
    #1;
    check("oor_sb_gnt1", {31'h0, m1_gnt}, 32'h1);
    tick();
    idle_inputs();
    m1_req = 1; m1_addr = 32'h3000;
    #1;
    check("oor_no_rmw_gnt1", {31'h0, m1_gnt}, 32'h1);
    check("oor_no_rmw_we", {31'h0, dm_we}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("oor_ld_rvalid1", {31'h0, m1_rvalid}, 32'h1);
    check("oor_ld_rdata1", m1_rdata, 32'h0);
    check("oor_we_count", 32'(we_count - we_snap), 32'h0);

    // be=0 store: granted, no write, no rvalid.
    m0_req = 1; m0_we = 1; m0_be = 4'h0; m0_addr = 32'h10; m0_wdata = 32'hFFFF_FFFF;
    #1;
    check("be0_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("be0_dm_we", {31'h0, dm_we}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("be0_no_rvalid0", {31'h0, m0_rvalid}, 32'h0);
    check("be0_mem4", mem[4], 32'hCAFE_BABE);
    tick();

    // Reset during RMW_WR drops the write and returns to IDLE with rr at m0.
    m0_req = 1; m0_we = 1; m0_be = 4'b1100; m0_addr = 32'h24; m0_wdata = 32'hAAAA_0000;
    #1;
    check("rstrmw_gnt0", {31'h0, m0_gnt}, 32'h1);
    tick();
    idle_inputs();
    reset = 1;
    #1;
    check("rstrmw_dm_we", {31'h0, dm_we}, 32'h0);
    tick();
    reset = 0;
    #1;
    check("rstrmw_mem9", mem[9], 32'h5566_7788);
    check("rstrmw_rdata0", m0_rdata, 32'h0);
    check("rstrmw_rdata1", m1_rdata, 32'h0);
    check("rstrmw_rvalid0", {31'h0, m0_rvalid}, 32'h0);
    m0_req = 1; m0_addr = 32'h24;
    m1_req = 1; m1_addr = 32'h24;
    #1;
    check("rstrmw_idle_gnt0", {31'h0, m0_gnt}, 32'h1);
    check("rstrmw_idle_gnt1", {31'h0, m1_gnt}, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("rstrmw_ld_rdata0", m0_rdata, 32'h5566_7788);
    tick();

    check("we_during_reset", 32'(we_in_reset), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

- Single-cycle arbiter and sequencer that shares the word-wide data memory (DM) between two requesters:
  - m0: the pipeline MEM stage.
  - m1: an auxiliary master, such as the loader or DMA.
- It grants one access per cycle using round-robin priority.
- It registers read responses.
- It turns partial-word stores (sb/sh) into a two-cycle read-modify-write, because DM only supports full-word writes.
- It sits between the requesters and DM, and drives DM's address, write-data and write-enable ports.

## Interface
- DM_WORDS, 3072: DM depth in words; addresses at or above DM_WORDS*4 are out of range.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_req  in  1  request valid (N = 0, 1); held with payload stable until mN_gnt.
- mN_we  in  1  1 = store, 0 = load.
- mN_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i].
- mN_addr  in  32  byte address; bits [1:0] ignored.
- mN_wdata  in  32  store data, already lane-aligned.
- mN_gnt  out  1  request accepted this cycle.
- mN_rvalid  out  1  load data valid; one-cycle pulse.
- mN_rdata  out  32  registered load data.
- dm_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dm_wdata  out  32  full-word write data.
- dm_we  out  1  DM write enable.
- dm_rdata  in  32  DM combinational read data for dm_addr.

## Operation
- States:
  - IDLE: accepts requests.
  - RMW_WR: second cycle of a partial store; no grants.
- Arbitration in IDLE:
  - If one requester is asserting, it is granted.
  - If both are asserting, the requester indicated by rr_ptr is granted.
  - After any grant, rr_ptr points to the other requester.
- Load: granted cycle drives dm_addr. At the edge, dm_rdata is captured into mN_rdata and mN_rvalid is set.
- Full store (be=4'hF): granted cycle drives dm_we=1 and dm_wdata=mN_wdata; committed at the edge.
- Partial store (be not 0 and not F):
  - Granted cycle reads the word.
  - At the edge, the merged word is latched: new bytes where be=1, old bytes otherwise.
  - Address and merged word are latched, and the FSM moves to RMW_WR.
  - RMW_WR drives dm_we=1 with the latched address and data, then returns to IDLE.
- Store with be=0: granted, no DM write.
- Stores produce no rvalid.
- Out-of-range address: granted; store suppressed (dm_we stays 0, no RMW_WR); load returns 32'h0.
- Requests arriving during RMW_WR wait; arbitration resumes in the next IDLE cycle.

## Timing
- Reset values:
  - FSM = IDLE, rr_ptr = m0.
  - mN_gnt = 0, mN_rvalid = 0, mN_rdata = 0.
  - dm_we = 0, dm_addr = 0, dm_wdata = 0.
- gnt is combinational from req, state and rr_ptr; at most one gnt per cycle.
- Load latency: rvalid rises exactly 1 cycle after the gnt cycle.
- Full-store occupancy is 1 cycle; partial-store occupancy is 2 cycles.
- Back-to-back loads from one requester get 1 grant per cycle when the other requester is idle.
- A load granted the cycle after a full store to the same word sees the new data.
- A load granted the cycle after an RMW_WR to the same word also sees the new data.
- Reset asserted during RMW_WR: the pending write is dropped (dm_we=0 in the reset cycle) and the FSM goes to IDLE.
- dm_we is never asserted while reset=1.

## Configuration
- DM_ARBITER_PERF_EN defined:
  - Adds outputs perf_grants0, perf_grants1 and perf_stalls (32 bits each, reset 0).
  - perf_grants0/perf_grants1 increment on each grant to the respective requester.
  - perf_stalls increments each cycle any req=1 with gnt=0.
  - Counters wrap at 2^32.
- DM_ARBITER_PERF_EN undefined: the counters and ports are absent; all other behaviour is identical.

## Structure
- Shared package/header holds:
  - FSM encodings (ST_IDLE, ST_RMW_WR).
  - BE_FULL = 4'hF.
  - The DM_WORDS default, kept equal to the DM depth constant.
- Sub-module dm_be_merge: combinational byte-lane merge of old word, new word and be into the merged word.
- The arbiter FSM, rr_ptr and response registers stay in dm_arbiter.

## Test plan
- m0 load at 0x10 with DM[4]=32'hCAFEBABE → gnt0 in cycle t; rvalid0=1 with rdata0=32'hCAFEBABE in t+1.
- Both assert loads right after reset → m0 granted first, m1 the next cycle; with both held, grants alternate 0,1,0,1.
- m1 sb with be=4'b0010 and wdata=32'h0000AB00 at 0x20, DM[8]=32'h11223344 → 2 busy cycles; DM[8]=32'h1122AB44; a m0 request in the RMW_WR cycle is granted one cycle later.
- m0 full store of 32'h12345678 to 0x30, then m1 load of 0x30 the next cycle → rdata1=32'h12345678.
- Store to address DM_WORDS*4 → gnt=1, dm_we never asserted; a load of the same address returns 32'h0.
- Reset asserted in the RMW_WR cycle → DM word unchanged, FSM in IDLE, all outputs at reset values.
